// File: rtl/sb_downsize_if.sv
// Switchboard stream bundle: payload, destination, end-of-packet and valid/ready handshake.
interface sb_downsize_if #(
  parameter int DW = 32
);
  logic [DW-1:0] data;
  logic [31:0]   dest;
  logic          last;
  logic          valid;
  logic          ready;

  modport master (output data, dest, last, valid, input ready);
  modport slave  (input data, dest, last, valid, output ready);
endinterface

// File: rtl/sb_downsize.sv
// Splits each DW_IN flit into R=DW_IN/DW_OUT LSB-first beats; beat 0 one cycle after accept, one beat/cycle.
// Backpressure: beats hold while out.ready=0; in.ready only on the final beat's transfer (or IDLE).
module sb_downsize #(
  parameter int DW_IN  = 416,
  parameter int DW_OUT = 32
) (
  input  logic          clk,
  input  logic          rst,
  sb_downsize_if.slave  in,
  sb_downsize_if.master out
);
  localparam int R  = (DW_OUT > 0) ? DW_IN / DW_OUT : 0;
  localparam int CW = (R > 1) ? $clog2(R) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'((R > 0) ? R - 1 : 0);

  generate
    if (DW_OUT < 1 || R < 1 || (R * DW_OUT) != DW_IN) begin : g_bad_width
      $error("sb_downsize: DW_OUT must divide DW_IN");
    end
  endgenerate

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [DW_IN-1:0] hold_data;
  logic [31:0]      hold_dest;
  logic             hold_last;
  logic             on_last_beat;

  assign on_last_beat = (cnt == LAST_CNT);

  assign out.valid = (state == SEND);
  assign out.data  = hold_data[int'(cnt) * DW_OUT +: DW_OUT];
  assign out.dest  = hold_dest;
  assign out.last  = hold_last && on_last_beat;

  // Combinational out.ready -> in.ready lets the next flit load on the final beat, so there is no bubble.
  assign in.ready = !rst && ((state == IDLE) || (on_last_beat && out.ready));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hold_data <= '0;
      hold_dest <= '0;
      hold_last <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in.valid) begin
            hold_data <= in.data;
            hold_dest <= in.dest;
            hold_last <= in.last;
            cnt       <= '0;
            state     <= SEND;
          end
        end
        SEND: begin
          if (out.ready) begin
            if (!on_last_beat) begin
              cnt <= cnt + 1'b1;
            end else if (in.valid) begin
              hold_data <= in.data;
              hold_dest <= in.dest;
              hold_last <= in.last;
              cnt       <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sb_downsize.sv
module tb_sb_downsize;
  localparam int AW = 128;
  localparam int BW = 32;
  localparam int OW = 32;
  localparam int RA = AW / OW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] dest;
    logic        last;
  } beat_t;

  beat_t qa[$];
  beat_t qb[$];

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   ordy_mode_a = 1;  // 0 low, 1 high, 2 random
  int   ordy_mode_b = 1;

  sb_downsize_if #(.DW(AW)) ia();
  sb_downsize_if #(.DW(OW)) oa();
  sb_downsize_if #(.DW(BW)) ib();
  sb_downsize_if #(.DW(OW)) ob();

  sb_downsize #(.DW_IN(AW), .DW_OUT(OW)) dut_a (.clk(clk), .rst(rst_a), .in(ia), .out(oa));
  sb_downsize #(.DW_IN(BW), .DW_OUT(OW)) dut_b (.clk(clk), .rst(rst_b), .in(ib), .out(ob));

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // ---------------- scoreboard monitors ----------------
  // Expected in.ready: nothing pending, or only the final beat pending and it leaves now.
  initial forever begin
    beat_t b;
    @(negedge clk); #1;
    if (rst_a) begin
      check("a_ready_in_reset", 64'(ia.ready), 64'd0);
      qa.delete();
    end else begin
      check("a_valid", 64'(oa.valid), 64'(qa.size() > 0));
      check("a_in_ready", 64'(ia.ready), 64'(qa.size() == 0 || (qa.size() == 1 && oa.ready)));
      if (oa.valid && oa.ready) begin
        if (qa.size() == 0) fail_now("a_unexpected_beat");
        else begin
          b = qa.pop_front();
          check("a_data", 64'(oa.data), 64'(b.data));
          check("a_dest", 64'(oa.dest), 64'(b.dest));
          check("a_last", 64'(oa.last), 64'(b.last));
        end
      end
    end
  end

  initial forever begin
    beat_t b;
    @(negedge clk); #1;
    if (rst_b) begin
      check("b_ready_in_reset", 64'(ib.ready), 64'd0);
      qb.delete();
    end else begin
      check("b_valid", 64'(ob.valid), 64'(qb.size() > 0));
      check("b_in_ready", 64'(ib.ready), 64'(qb.size() == 0 || (qb.size() == 1 && ob.ready)));
      if (ob.valid && ob.ready) begin
        if (qb.size() == 0) fail_now("b_unexpected_beat");
        else begin
          b = qb.pop_front();
          check("b_data", 64'(ob.data), 64'(b.data));
          check("b_dest", 64'(ob.dest), 64'(b.dest));
          check("b_last", 64'(ob.last), 64'(b.last));
        end
      end
    end
  end

  // ---------------- stimulus: instance A (R=4) ----------------
  task automatic set_ordy_a();
    oa.ready = (ordy_mode_a == 2) ? ($urandom_range(0, 3) != 0) : (ordy_mode_a == 1);
  endtask

  task automatic idle_a(int n);
    repeat (n) begin
      @(negedge clk);
      set_ordy_a();
      ia.valid = 1'b0;
      ia.data  = {$urandom, $urandom, $urandom, $urandom};
      ia.dest  = $urandom;
      ia.last  = 1'($urandom);
    end
  endtask

  task automatic drive_a(logic [AW-1:0] d, logic [31:0] dst, logic l);
    int waited = 0;
    forever begin
      @(negedge clk);
      set_ordy_a();
      ia.valid = 1'b1;
      ia.data  = d;
      ia.dest  = dst;
      ia.last  = l;
      #2;
      if (ia.ready) begin
        for (int i = 0; i < RA; i++) qa.push_back('{d[i*OW +: OW], dst, l && (i == RA - 1)});
        break;
      end
      if (++waited > 200) begin
        fail_now("a_accept_timeout");
        break;
      end
    end
  endtask

  // ---------------- stimulus: instance B (R=1) ----------------
  task automatic set_ordy_b();
    ob.ready = (ordy_mode_b == 2) ? ($urandom_range(0, 3) != 0) : (ordy_mode_b == 1);
  endtask

  task automatic idle_b(int n);
    repeat (n) begin
      @(negedge clk);
      set_ordy_b();
      ib.valid = 1'b0;
      ib.data  = $urandom;
      ib.dest  = $urandom;
      ib.last  = 1'($urandom);
    end
  endtask

  task automatic drive_b(logic [BW-1:0] d, logic [31:0] dst, logic l);
    int waited = 0;
    forever begin
      @(negedge clk);
      set_ordy_b();
      ib.valid = 1'b1;
      ib.data  = d;
      ib.dest  = dst;
      ib.last  = l;
      #2;
      if (ib.ready) begin
        qb.push_back('{d, dst, l});
        break;
      end
      if (++waited > 200) begin
        fail_now("b_accept_timeout");
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ia.valid = 1'b0; ia.data = '0; ia.dest = '0; ia.last = 1'b0; oa.ready = 1'b0;
    ib.valid = 1'b0; ib.data = '0; ib.dest = '0; ib.last = 1'b0; ob.ready = 1'b0;
    fork
      begin : seq_a
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        #3;
        check("a_rst_valid", 64'(oa.valid), 64'd0);
        check("a_rst_data", 64'(oa.data), 64'd0);
        check("a_rst_dest", 64'(oa.dest), 64'd0);
        check("a_rst_last", 64'(oa.last), 64'd0);
        check("a_ready_after_rst", 64'(ia.ready), 64'd1);

        ordy_mode_a = 1;
        drive_a(128'h44444444_33333333_22222222_11111111, 32'd5, 1'b1);
        idle_a(6);
        drive_a({$urandom, $urandom, $urandom, $urandom}, 32'd7, 1'b1);
        drive_a({$urandom, $urandom, $urandom, $urandom}, 32'd8, 1'b1);
        idle_a(10);

        // Stall while beat 1 is presented.
        drive_a(128'h44444444_33333333_22222222_11111111, 32'd6, 1'b1);
        idle_a(1);
        repeat (3) begin
          @(negedge clk);
          oa.ready = 1'b0;
          ia.valid = 1'b0;
          #3;
          check("a_stall_data", 64'(oa.data), 64'h22222222);
          check("a_stall_in_ready", 64'(ia.ready), 64'd0);
        end
        idle_a(6);

        drive_a({$urandom, $urandom, $urandom, $urandom}, 32'd3, 1'b0);
        drive_a({$urandom, $urandom, $urandom, $urandom}, 32'd3, 1'b1);
        idle_a(10);

        // Reset after beat 1 has been accepted.
        drive_a({$urandom, $urandom, $urandom, $urandom}, 32'd4, 1'b1);
        idle_a(2);
        @(negedge clk);
        rst_a = 1'b1;
        ia.valid = 1'b0;
        @(negedge clk);
        rst_a = 1'b0;
        #3;
        check("a_midrst_valid", 64'(oa.valid), 64'd0);
        check("a_midrst_data", 64'(oa.data), 64'd0);
        check("a_midrst_dest", 64'(oa.dest), 64'd0);
        check("a_midrst_last", 64'(oa.last), 64'd0);
        drive_a({4{32'hDDDDDDDD}} ^ 128'h3_00000002_00000001_00000000, 32'd9, 1'b1);
        idle_a(8);

        ordy_mode_a = 2;
        for (int i = 0; i < 150; i++) begin
          drive_a({$urandom, $urandom, $urandom, $urandom}, $urandom, 1'($urandom));
          if ($urandom_range(0, 2) == 0) idle_a($urandom_range(1, 3));
        end
        ordy_mode_a = 1;
        idle_a(12);
        check("a_drained", 64'(qa.size()), 64'd0);
      end
      begin : seq_b
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        #3;
        check("b_rst_valid", 64'(ob.valid), 64'd0);
        check("b_rst_data", 64'(ob.data), 64'd0);

        ordy_mode_b = 1;
        drive_b(32'hA, 32'd1, 1'b1);
        drive_b(32'hB, 32'd2, 1'b0);
        idle_b(4);

        ordy_mode_b = 2;
        for (int i = 0; i < 120; i++) begin
          drive_b($urandom, $urandom, 1'($urandom));
          if ($urandom_range(0, 3) == 0) idle_b($urandom_range(1, 2));
        end
        ordy_mode_b = 1;
        idle_b(6);
        check("b_drained", 64'(qb.size()), 64'd0);
      end
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
